// File: rtl/frame_fill_pkg.sv
// Shared types, constants and the row-start helper for the frame fill engine.
package frame_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int DEF_HRES = 640;
    localparam int DEF_VRES = 480;
    localparam int ADDR_W   = 19;   // video RAM address width
    localparam int COORD_W  = 12;   // coordinate width, one bit wider than the inputs so sums never wrap

    // Address of the first pixel in row y. The 640 stride is built from two shifts
    // (512 + 128) so the common resolution needs no multiplier at all.
    function automatic logic [ADDR_W-1:0] row_start(input logic [COORD_W-1:0] y, input int hres);
        logic [ADDR_W-1:0] w_y;
        w_y = {{(ADDR_W-COORD_W){1'b0}}, y};
        if (hres == 640) begin
            return (w_y << 9) + (w_y << 7);
        end
        return w_y * ADDR_W'(hres);
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Raster walker for the fill engine: x/y counters and a row-base accumulator.
// The current pixel address is row_base + x; moving to the next row adds one stride
// to row_base, so the only multiply happens once when a command is loaded.
module frame_addr_gen
    import frame_fill_pkg::*;
#(
    parameter int HRES = DEF_HRES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,        // capture a new clipped rectangle
    input  logic               i_advance,     // step to the next pixel in raster order
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x_end,       // exclusive
    input  logic [COORD_W-1:0] i_y_end,       // exclusive
    output logic [ADDR_W-1:0]  o_first_addr,  // address of (i_x0, i_y0), from the inputs
    output logic [ADDR_W-1:0]  o_next_addr,   // address of the pixel after the current one
    output logic               o_last         // current pixel is the last of the rectangle
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(HRES);
    localparam int                PAD_W  = ADDR_W - COORD_W;

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_x_end;
    logic [COORD_W-1:0] r_y_end;
    logic [ADDR_W-1:0]  r_row_base;

    logic               w_row_end;

    assign w_row_end    = (r_x == r_x_end - 12'd1);
    assign o_last       = w_row_end && (r_y == r_y_end - 12'd1);
    assign o_first_addr = row_start(i_y0, HRES) + {{PAD_W{1'b0}}, i_x0};
    assign o_next_addr  = w_row_end ? (r_row_base + STRIDE + {{PAD_W{1'b0}}, r_x0})
                                    : (r_row_base + {{PAD_W{1'b0}}, r_x} + 19'd1);

    // Counter and accumulator update: load a rectangle, then walk it x-fastest.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_x0       <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
        end else if (i_load) begin
            r_x        <= i_x0;
            r_y        <= i_y0;
            r_x0       <= i_x0;
            r_x_end    <= i_x_end;
            r_y_end    <= i_y_end;
            r_row_base <= row_start(i_y0, HRES);
        end else if (i_advance) begin
            if (w_row_end) begin
                r_x        <= r_x0;
                r_y        <= r_y + 12'd1;
                r_row_base <= r_row_base + STRIDE;
            end else begin
                r_x <= r_x + 12'd1;
            end
        end
    end

endmodule

// File: rtl/frame_fill_engine.sv
// Rectangle fill engine: clips a command to the screen and writes one pixel per clock
// into the video RAM write port, then pulses done for one cycle.
module frame_fill_engine
    import frame_fill_pkg::*;
#(
    parameter int DW   = 9,
    parameter int HRES = DEF_HRES,
    parameter int VRES = DEF_VRES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [10:0]       x0,
    input  logic [10:0]       y0,
    input  logic [10:0]       width,
    input  logic [10:0]       height,
    input  logic [DW-1:0]     color,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_pix,
    output logic [DW-1:0]     wr_data_pix,
    output logic              write_pix
);

    localparam logic [COORD_W-1:0] HRES_C = COORD_W'(HRES);
    localparam logic [COORD_W-1:0] VRES_C = COORD_W'(VRES);

    fill_state_t        r_state;

    logic [COORD_W-1:0] w_x0;
    logic [COORD_W-1:0] w_y0;
    logic [COORD_W-1:0] w_x_sum;
    logic [COORD_W-1:0] w_y_sum;
    logic [COORD_W-1:0] w_x_end;
    logic [COORD_W-1:0] w_y_end;
    logic               w_empty;
    logic               w_load;
    logic               w_advance;
    logic [ADDR_W-1:0]  w_first_addr;
    logic [ADDR_W-1:0]  w_next_addr;
    logic               w_last;

    // Clip the requested rectangle against the screen and flag commands with nothing to draw.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_x0    = {1'b0, x0};
        w_y0    = {1'b0, y0};
        w_x_sum = {1'b0, x0} + {1'b0, width};
        w_y_sum = {1'b0, y0} + {1'b0, height};
        w_x_end = w_x_sum;
        w_y_end = w_y_sum;
        if (w_x_sum > HRES_C) begin
            w_x_end = HRES_C;
        end
        if (w_y_sum > VRES_C) begin
            w_y_end = VRES_C;
        end
        w_empty = (w_x0 >= HRES_C) || (w_y0 >= VRES_C) || (width == '0) || (height == '0);
    end

    assign w_load    = (r_state == IDLE) && start && !w_empty;
    assign w_advance = (r_state == FILL) && !w_last;

    frame_addr_gen #(
        .HRES (HRES)
    ) u_addr_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_advance    (w_advance),
        .i_x0         (w_x0),
        .i_y0         (w_y0),
        .i_x_end      (w_x_end),
        .i_y_end      (w_y_end),
        .o_first_addr (w_first_addr),
        .o_next_addr  (w_next_addr),
        .o_last       (w_last)
    );

    // Command FSM with registered RAM-port and status outputs; the first pixel is
    // presented in the cycle right after start is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            write_pix   <= 1'b0;
            addr_pix    <= '0;
            wr_data_pix <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (w_empty) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state     <= FILL;
                            write_pix   <= 1'b1;
                            addr_pix    <= w_first_addr;
                            wr_data_pix <= color;
                        end
                    end
                end
                FILL: begin
                    if (w_last) begin
                        r_state   <= DONE;
                        write_pix <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        addr_pix <= w_next_addr;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    write_pix <= 1'b0;
                end
            endcase
        end
    end

endmodule
